fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer that feeds the decode stage. Owns the program counter, issues single-outstanding requests to instruction memory, and presents one registered 16-bit instruction per cycle to `decode_module.inst`. Holds the instruction while decode reports a hazard stall, and redirects on taken branches from `brbus`. Stops fetching permanently on a HALT instruction.

## Interface
- `RESET_PC`, default 16'h0000: first fetch address after reset.
- `HALT_OP`, default 4'hF: opcode (`inst[15:12]`) treated as HALT.

- `clock`  in  1  clock. Already decided.
- `resetn`  in  1  reset, asynchronous, active-low. Already decided.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  16  word address; stable while `imem_req` is high.
- `imem_ack`  in  1  response valid this cycle; sampled only while `imem_req` is high.
- `imem_rdata`  in  16  instruction word; valid with `imem_ack`.
- `brbus`  in  18  from decode: [17] consume (no hazard), [16] taken, [15:0] sign-extended offset.
- `inst`  out  16  registered instruction to decode; 16'h0000 (NOP) when empty.
- `inst_pc`  out  16  address of `inst`; don't-care when `inst` is a bubble.
- `halted`  out  1  high once HALT has been consumed.

## Operation
- Internal `inst_vld` marks `inst` as a real instruction. `consume = inst_vld & brbus[17]`. `redirect = consume & brbus[16]`. `target = inst_pc + 1 + brbus[15:0]`, mod 2^16.
- Bubbles are 16'h0000. Decode always accepts a bubble, so `brbus[17]` is ignored when `inst_vld = 0`.
- When a redirect occurs, or when HALT is consumed (`inst[15:12] == HALT_OP`), `inst` and `inst_vld` are cleared.
- One-entry skid buffer (`buf`, `buf_pc`) holds a returned word when the `inst` slot is occupied and not being consumed.
- States:
  - S_IDLE: one cycle after reset release. Go to S_REQ.
  - S_REQ: `imem_req` = 1, `imem_addr` = `fetch_pc`.
    - On ack with no redirect or halt: if the slot is free or being consumed, load `inst` <= `rdata`, `inst_pc` <= `fetch_pc`, `fetch_pc` += 1, and stay in S_REQ. Otherwise write the skid buffer, `fetch_pc` += 1, and go to S_FULL.
    - Redirect with ack: discard `rdata`, `fetch_pc` <= `target`, stay in S_REQ.
    - Redirect without ack: `redir_pc` <= `target`, go to S_SQUASH.
    - HALT consumed with ack: go to S_HALT. Without ack: go to S_SQUASH with `halt_pend` set.
  - S_FULL: `imem_req` = 0.
    - On consume (no redirect or halt): `inst` <= `buf`, go to S_REQ.
    - On redirect: drop `buf`, `fetch_pc` <= `target`, go to S_REQ.
    - On HALT: go to S_HALT.
  - S_SQUASH: keep `imem_req` high on the old address. On ack, discard the data. Then go to S_HALT if `halt_pend`, else set `fetch_pc` <= `redir_pc` and go to S_REQ.
  - S_HALT: `imem_req` = 0, `halted` = 1, `inst` = NOP. Terminal until reset.
- Priority within a cycle: HALT consume > redirect > sequential.
- Reset mid-transaction: `imem_req` drops immediately (async reset). Any ack arriving before S_REQ is re-entered is ignored.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = `RESET_PC`
  - `inst` = 16'h0000, `inst_pc` = 0, `inst_vld` = 0
  - `halted` = 0, state = S_IDLE, `fetch_pc` = `RESET_PC`
- First `imem_req` goes high in the 2nd cycle after `resetn` rises.
- With same-cycle ack, steady-state throughput is 1 instruction per cycle. Fetch-to-`inst` latency is 1 edge.
- Taken-branch penalty with zero-wait memory: the branch is consumed at edge N, the target request is issued in cycle N+1, and the target is on `inst` after edge N+1. This leaves one bubble.
- Stall: while `brbus[17]` = 0, `inst` and `inst_pc` hold exactly. At most one further word is fetched, into the skid buffer.

## Structure
- Shared package `fetch_pkg` holds:
  - state encoding (S_IDLE, S_REQ, S_FULL, S_SQUASH, S_HALT)
  - `INST_NOP` = 16'h0000
  - brbus field indices: `BR_VALID` = 17, `BR_TAKEN` = 16, offset 15:0
- Sub-module `fetch_skid_buf`: the one-entry data+pc holding register with load/clear.

## Test plan
- Sequential fetch, zero-wait memory at `RESET_PC` = 0 holding 16'h1240, 16'h2250, …: `inst` shows each word on consecutive cycles, and `inst_pc` = 0, 1, 2.
- Hazard stall: hold `brbus[17]` = 0 for 3 cycles while `inst` = 16'h1240. `inst` is stable, exactly one extra request is made, the state is S_FULL, and after release the buffered word appears on the next edge.
- Taken branch at `inst_pc` = 16'h0010 with offset 16'hFFFC: next request address = 16'h000D, with one bubble (16'h0000) on `inst`.
- Redirect while a request is unacked, ack delayed 2 cycles: `imem_addr` stays at the old address until ack, the data is discarded, then a request to `target` is issued.
- HALT 16'hF000 consumed: `halted` = 1 after the edge, no further `imem_req`, and `inst` = 0 permanently. Same case with an outstanding request completes that request first.
- Assert `resetn` low mid-request: `imem_req` drops asynchronously, and after release fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// bubble encoding, brbus field positions and the branch-target helper.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_FULL   = 3'd2,
    S_SQUASH = 3'd3,
    S_HALT   = 3'd4
  } fetch_state_e;

  localparam logic [15:0] INST_NOP = 16'h0000;

  localparam int BR_VALID   = 17;
  localparam int BR_TAKEN   = 16;
  localparam int BR_OFF_MSB = 15;

  // Branch target is relative to the word after the branch, wrapping at 2^16.
  function automatic logic [15:0] branch_target(input logic [15:0] pc, input logic [15:0] offset);
    return pc + 16'd1 + offset;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word (and its address) that
// returned while the decode slot was occupied.
module fetch_skid_buf (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] data_in,
  input  logic [15:0] pc_in,
  output logic [15:0] data,
  output logic [15:0] pc
);

  logic [15:0] data_r;
  logic [15:0] pc_r;

  // Buffer storage; clear wins over load.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_r <= 16'h0000;
      pc_r   <= 16'h0000;
    end else if (clear) begin
      data_r <= 16'h0000;
      pc_r   <= 16'h0000;
    end else if (load) begin
      data_r <= data_in;
      pc_r   <= pc_in;
    end else begin
      data_r <= data_r;
      pc_r   <= pc_r;
    end
  end

  assign data = data_r;
  assign pc   = pc_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding
// memory requests and presents one registered instruction to decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic [17:0] brbus,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        halted
);

  fetch_state_e state_r, state_s;
  logic [15:0]  fetch_pc_r, fetch_pc_s;
  logic [15:0]  redir_pc_r, redir_pc_s;
  logic         halt_pend_r, halt_pend_s;
  logic [15:0]  inst_r, inst_s;
  logic [15:0]  inst_pc_r, inst_pc_s;
  logic         inst_vld_r, inst_vld_s;
  logic         halted_r, halted_s;
  logic         req_r;
  logic         buf_load_s, buf_clear_s;
  logic [15:0]  buf_data_s, buf_pc_s;
  logic         consume_s, halt_s, redirect_s;
  logic [15:0]  target_s;

  assign consume_s  = inst_vld_r & brbus[BR_VALID];
  assign halt_s     = consume_s & (inst_r[15:12] == HALT_OP);
  assign redirect_s = consume_s & brbus[BR_TAKEN] & ~halt_s;
  assign target_s   = branch_target(inst_pc_r, brbus[BR_OFF_MSB:0]);

  fetch_skid_buf u_skid (
    .clock   (clock),
    .resetn  (resetn),
    .load    (buf_load_s),
    .clear   (buf_clear_s),
    .data_in (imem_rdata),
    .pc_in   (fetch_pc_r),
    .data    (buf_data_s),
    .pc      (buf_pc_s)
  );

  // Next-state and datapath decisions; priority is HALT > redirect > sequential.
  always_comb begin
    state_s     = state_r;
    fetch_pc_s  = fetch_pc_r;
    redir_pc_s  = redir_pc_r;
    halt_pend_s = halt_pend_r;
    inst_pc_s   = inst_pc_r;
    buf_load_s  = 1'b0;
    buf_clear_s = 1'b0;
    // A consumed instruction leaves a bubble unless something refills the slot.
    if (consume_s) begin
      inst_s     = INST_NOP;
      inst_vld_s = 1'b0;
    end else begin
      inst_s     = inst_r;
      inst_vld_s = inst_vld_r;
    end
    if (halt_s) begin
      halted_s = 1'b1;
    end else begin
      halted_s = halted_r;
    end
    case (state_r)
      S_IDLE: state_s = S_REQ;
      S_REQ: begin
        if (halt_s) begin
          state_s     = imem_ack ? S_HALT : S_SQUASH;
          halt_pend_s = ~imem_ack;
        end else if (redirect_s) begin
          if (imem_ack) begin
            fetch_pc_s = target_s;
          end else begin
            redir_pc_s = target_s;
            state_s    = S_SQUASH;
          end
        end else if (imem_ack) begin
          fetch_pc_s = fetch_pc_r + 16'd1;
          if (!inst_vld_r || consume_s) begin
            inst_s     = imem_rdata;
            inst_pc_s  = fetch_pc_r;
            inst_vld_s = 1'b1;
          end else begin
            buf_load_s = 1'b1;
            state_s    = S_FULL;
          end
        end else begin
          state_s = S_REQ;
        end
      end
      S_FULL: begin
        if (halt_s) begin
          state_s = S_HALT;
        end else if (redirect_s) begin
          buf_clear_s = 1'b1;
          fetch_pc_s  = target_s;
          state_s     = S_REQ;
        end else if (consume_s) begin
          inst_s     = buf_data_s;
          inst_pc_s  = buf_pc_s;
          inst_vld_s = 1'b1;
          state_s    = S_REQ;
        end else begin
          state_s = S_FULL;
        end
      end
      S_SQUASH: begin
        // The in-flight request must complete before the PC may move.
        if (imem_ack) begin
          if (halt_pend_r) begin
            state_s = S_HALT;
          end else begin
            fetch_pc_s = redir_pc_r;
            state_s    = S_REQ;
          end
        end else begin
          state_s = S_SQUASH;
        end
      end
      S_HALT: begin
        inst_s     = INST_NOP;
        inst_vld_s = 1'b0;
        halted_s   = 1'b1;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State and datapath registers; imem_req is registered from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      fetch_pc_r  <= RESET_PC;
      redir_pc_r  <= 16'h0000;
      halt_pend_r <= 1'b0;
      inst_r      <= INST_NOP;
      inst_pc_r   <= 16'h0000;
      inst_vld_r  <= 1'b0;
      halted_r    <= 1'b0;
      req_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      redir_pc_r  <= redir_pc_s;
      halt_pend_r <= halt_pend_s;
      inst_r      <= inst_s;
      inst_pc_r   <= inst_pc_s;
      inst_vld_r  <= inst_vld_s;
      halted_r    <= halted_s;
      req_r       <= (state_s == S_REQ) || (state_s == S_SQUASH);
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = fetch_pc_r;
  assign inst      = inst_r;
  assign inst_pc   = inst_pc_r;
  assign halted    = halted_r;

endmodule
